// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extends I/S/B/J/U immediates to XLEN and forms pc + imm.
// Latency: one cycle from an accepted input to out_valid with registered results.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds until drained.
// Optional feature macro: IMM_GEN_ZIMM_EN (imm_src 101 selects the CSR zimm format).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             valid_q;
    logic [XLEN-1:0]  imm_q,    imm_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [XLEN-1:0]  u_imm;
    logic             xfer;

    // The opcode field never feeds an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // U-type fills bits 31:12 directly; sign bits exist only above bit 31.
    generate
        if (XLEN == 32) begin : g_u32
            assign u_imm = {instr[31:12], 12'b0};
        end else begin : g_uwide
            assign u_imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
        end
    endgenerate

    assign in_ready = !valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    // Format decode: select the extended immediate and flag unsupported codes.
    always_comb begin
        imm_d     = '0;
        illegal_d = 1'b0;
        case (imm_src)
            3'b000: imm_d = {{(XLEN-12){instr[31]}}, instr[31:20]};
            3'b001: imm_d = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: imm_d = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: imm_d = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: imm_d = u_imm;
`ifdef IMM_GEN_ZIMM_EN
            3'b101: imm_d = {{(XLEN-5){1'b0}}, instr[19:15]};
`endif
            default: begin
                imm_d     = '0;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Branch/jump target; carry-out is dropped so the sum wraps modulo 2^XLEN.
    always_comb begin
        target_d = pc + imm_d;
    end

    // Saturating count of accepted illegal formats; stalls never touch it.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer && illegal_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output stage: load only on transfer, drain when downstream takes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            target_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (xfer) begin
                valid_q   <= 1'b1;
                imm_q     <= imm_d;
                target_q  <= target_d;
                illegal_q <= illegal_d;
            end else if (out_ready) begin
                valid_q   <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_imm     = imm_q;
    assign out_target  = target_q;
    assign out_illegal = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8 instances share stimulus.
// Table vectors, hand sequences for stall/illegal/reset corners, then randomized traffic vs a model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after the edge.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [31:0] pc;
    logic [63:0] pc64;
    logic        out_ready;

    logic        in_ready, in_ready64;
    logic        out_valid, out_valid64;
    logic [31:0] out_imm, out_target;
    logic [63:0] out_imm64, out_target64;
    logic        out_illegal, out_illegal64;
    logic [1:0]  illegal_cnt;
    logic [7:0]  illegal_cnt64;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (what the outputs must show after the last edge)
    logic        e_vld, e_ill;
    logic [31:0] e_imm32, e_tgt32;
    logic [63:0] e_imm64, e_tgt64;
    int          e_cnt2, e_cnt8;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_src(imm_src), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_target(out_target), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .pc(pc64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_target(out_target64), .out_illegal(out_illegal64), .illegal_cnt(illegal_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [2:0] src);
`ifdef IMM_GEN_ZIMM_EN
        return src >= 3'd6;
`else
        return src >= 3'd5;
`endif
    endfunction

    // Immediate as a signed integer value, built from the field weights of each format.
    function automatic longint ref_imm(input logic [31:0] w, input logic [2:0] src);
        longint neg12, neg20, neg32;
        neg12 = w[31] ? 64'sd4096    : 64'sd0;
        neg20 = w[31] ? 64'sd1048576 : 64'sd0;
        neg32 = w[31] ? 64'sd4294967296 : 64'sd0;
        if (is_illegal(src)) return 0;
        case (src)
            3'd0: return longint'(w[31:20]) - neg12;
            3'd1: return longint'({w[31:25], w[11:7]}) - neg12;
            3'd2: return longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                         + longint'(w[11:8]) * 2 - neg12;
            3'd3: return longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                         + longint'(w[30:21]) * 2 - neg20;
            3'd4: return longint'(w[31:12]) * 4096 - neg32;
            default: return longint'(w[19:15]);
        endcase
    endfunction

    // One clock: check ready, advance the model on the edge, then check the registered outputs.
    task automatic cycle();
        logic   acc;
        longint v;
        #1;
        chk("in_ready", in_ready, !e_vld || out_ready);
        chk("in_ready64", in_ready64, !e_vld || out_ready);
        acc = !rst && in_valid && (!e_vld || out_ready);
        v = ref_imm(instr, imm_src);
        @(posedge clk);
        #1;
        if (rst) begin
            e_vld = 0; e_ill = 0; e_imm32 = 0; e_tgt32 = 0; e_imm64 = 0; e_tgt64 = 0;
            e_cnt2 = 0; e_cnt8 = 0;
        end else if (acc) begin
            e_vld   = 1;
            e_ill   = is_illegal(imm_src);
            e_imm64 = v;
            e_imm32 = e_imm64[31:0];
            e_tgt32 = pc + e_imm32;
            e_tgt64 = pc64 + e_imm64;
            if (e_ill) begin
                e_cnt2 = (e_cnt2 + 1 > 3)   ? 3   : e_cnt2 + 1;
                e_cnt8 = (e_cnt8 + 1 > 255) ? 255 : e_cnt8 + 1;
            end
        end else if (out_ready) begin
            e_vld = 0;
        end
        chk("out_valid", out_valid, e_vld);
        chk("out_valid64", out_valid64, e_vld);
        chk("cnt", illegal_cnt, e_cnt2);
        chk("cnt64", illegal_cnt64, e_cnt8);
        if (e_vld) begin
            chk("imm", out_imm, e_imm32);
            chk("target", out_target, e_tgt32);
            chk("illegal", out_illegal, e_ill);
            chk("imm64", out_imm64, e_imm64);
            chk("target64", out_target64, e_tgt64);
            chk("illegal64", out_illegal64, e_ill);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    vec_t vecs[8];
    int   sat_seq[5];

    initial begin
        vecs[0] = '{32'hFFF00093, 3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[1] = '{32'hFE000EE3, 3'b010, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0};
        vecs[2] = '{32'h0080006F, 3'b011, 32'h0000_0200, 32'h0000_0008, 32'h0000_0208, 1'b0};
        vecs[3] = '{32'h12345037, 3'b100, 32'h0000_0000, 32'h1234_5000, 32'h1234_5000, 1'b0};
        vecs[4] = '{32'hFE112E23, 3'b001, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0};
        vecs[5] = '{32'h00100093, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h80000037, 3'b100, 32'h0000_0010, 32'h8000_0000, 32'h8000_0010, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1};
        sat_seq = '{1, 2, 3, 3, 3};

        rst = 1; in_valid = 0; instr = 0; imm_src = 0; pc = 0; pc64 = 0; out_ready = 1;
        e_vld = 0; e_ill = 0; e_imm32 = 0; e_tgt32 = 0; e_imm64 = 0; e_tgt64 = 0;
        e_cnt2 = 0; e_cnt8 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_target", out_target, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_valid64", out_valid64, 0);
        rst = 0;

        // Table vectors at full throughput
        for (int i = 0; i < 8; i++) begin
            instr = vecs[i].instr; imm_src = vecs[i].src; pc = vecs[i].pc;
            pc64 = {32'h0, vecs[i].pc}; in_valid = 1; out_ready = 1;
            cycle();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("vec%0d_target", i), out_target, vecs[i].tgt);
            chk($sformatf("vec%0d_illegal", i), out_illegal, vecs[i].ill);
            if (i == 0) chk("vec0_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        end

        // Backpressure: hold result A for three cycles while B waits
        instr = 32'h00500093; imm_src = 0; pc = 32'h10; pc64 = 64'h10; in_valid = 1; out_ready = 1;
        cycle();
        chk("bp_first_imm", out_imm, 32'h5);
        out_ready = 0; instr = 32'h00700093;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_rdy", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_imm", out_imm, 32'h5);
            chk("bp_hold_target", out_target, 32'h15);
        end
        out_ready = 1;
        cycle();
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_imm", out_imm, 32'h7);
        chk("bp_next_target", out_target, 32'h17);
        in_valid = 0;
        cycle();
        chk("bp_drain_valid", out_valid, 0);

        // Illegal code saturation on the 2-bit counter
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < 5; i++) begin
            instr = $urandom; imm_src = 3'b111; pc = 32'h40 + 4 * i; pc64 = {32'h0, pc};
            in_valid = 1; out_ready = 1;
            cycle();
            chk("ill_flag", out_illegal, 1);
            chk("ill_imm", out_imm, 0);
            chk("ill_target", out_target, 32'h40 + 4 * i);
            chk("ill_cnt", illegal_cnt, sat_seq[i]);
        end

        // Code 101: zimm when enabled, otherwise illegal
        instr = 32'h000F8073; imm_src = 3'b101; pc = 32'h80; pc64 = 64'h80;
        cycle();
`ifdef IMM_GEN_ZIMM_EN
        chk("zimm_imm", out_imm, 32'h1F);
        chk("zimm_illegal", out_illegal, 0);
        chk("zimm_cnt", illegal_cnt, 3);
`else
        chk("c101_imm", out_imm, 0);
        chk("c101_illegal", out_illegal, 1);
        chk("c101_target", out_target, 32'h80);
`endif

        // Reset while a result is stalled, with a same-cycle illegal input
        instr = 32'h00500093; imm_src = 0; in_valid = 1; out_ready = 1;
        cycle();
        out_ready = 0; imm_src = 3'b111; rst = 1;
        cycle();
        rst = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", illegal_cnt, 0);
        chk("mid_rst_cnt64", illegal_cnt64, 0);
        chk("mid_rst_rdy", in_ready, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = $urandom;
            imm_src   = 3'($urandom_range(0, 7));
            pc        = $urandom;
            pc64      = {$urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
